// File: rtl/spi3w_slave_regfile_if.sv
// Pin and backdoor bundle for the 3-wire SPI responder register file.
// wr_valid is a one-clock strobe with no ready: a write byte is reported exactly once and never stalls.
interface spi3w_slave_regfile_if #(
  parameter int ADDR_W = 6
);
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_sdio_i;
  logic              spi_sdio_o;
  logic              spi_sdio_oe;
  logic              busy;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_rdata;
  logic [7:0]        err_cnt;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_sdio_i, host_addr,
    output spi_sdio_o, spi_sdio_oe, busy, wr_valid, wr_addr, wr_data, host_rdata, err_cnt
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_sdio_i, host_addr,
    input  spi_sdio_o, spi_sdio_oe, busy, wr_valid, wr_addr, wr_data, host_rdata, err_cnt
  );
endinterface

// File: rtl/spi3w_slave_regfile.sv
// 3-wire SPI responder (16-bit header, MSB-first bytes) over a byte register file, oversampled in clk.
// Optional abort counter enabled with `define SPI_SLV_ERR_CNT_EN.
module spi3w_slave_regfile #(
  parameter int REG_DEPTH   = 64,
  parameter int ADDR_W      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  spi3w_slave_regfile_if.slave  bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, sdio_sync_q, sdio_sync_d;
  logic sclk_d1_q, sclk_d1_d, cs_d1_q, cs_d1_d;
  logic [14:0] instr_q, instr_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_cnt_q, byte_cnt_d, mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [7:0] shift_q, shift_d, wr_data_q, wr_data_d, host_rdata_q, host_rdata_d, rd_byte;
  logic rd_loaded_q, rd_loaded_d, oe_q, oe_d, sdio_o_q, sdio_o_d, wr_valid_q, wr_valid_d;
  logic [7:0] regs_q [REG_DEPTH];
  logic [7:0] regs_d [REG_DEPTH];

  logic sclk_s, cs_s, sdio_s, sclk_rise, sclk_fall, cs_rise, cs_fall, last_byte;
  logic [15:0] instr_full;
  logic unused_instr_bits;

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign sdio_s     = sdio_sync_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_d1_q;
  assign sclk_fall  = ~sclk_s & sclk_d1_q;
  assign cs_rise    = cs_s & ~cs_d1_q;
  assign cs_fall    = ~cs_s & cs_d1_q;
  assign instr_full = {instr_q, sdio_s};
  assign unused_instr_bits = ^instr_full[12:ADDR_W];
  // Stream mode (11) never terminates on count.
  assign last_byte  = (mode_q != 2'b11) && (byte_cnt_q == mode_q);
  assign rd_byte    = regs_q[addr_q - 1'b1];

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
    sdio_sync_d  = {sdio_sync_q[SYNC_STAGES-2:0], bus.spi_sdio_i};
    sclk_d1_d    = sclk_s;
    cs_d1_d      = cs_s;
    state_d      = state_q;
    instr_d      = instr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    shift_d      = shift_q;
    rd_loaded_d  = rd_loaded_q;
    oe_d         = oe_q;
    sdio_o_d     = sdio_o_q;
    wr_valid_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    regs_d       = regs_q;
    host_rdata_d = regs_q[bus.host_addr];

    case (state_q)
      IDLE: if (cs_fall) begin
        state_d   = INSTR;
        bit_cnt_d = '0;
        instr_d   = '0;
      end
      INSTR: if (sclk_rise) begin
        instr_d   = instr_full[14:0];
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) begin
          bit_cnt_d   = '0;
          byte_cnt_d  = '0;
          mode_d      = instr_full[14:13];
          addr_d      = instr_full[ADDR_W-1:0];
          rd_loaded_d = 1'b0;
          state_d     = instr_full[15] ? RDATA : WDATA;
        end
      end
      WDATA: if (sclk_rise) begin
        shift_d   = {shift_q[6:0], sdio_s};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd7) begin
          bit_cnt_d      = '0;
          regs_d[addr_q] = shift_d;
          wr_valid_d     = 1'b1;
          wr_addr_d      = addr_q;
          wr_data_d      = shift_d;
          addr_d         = addr_q - 1'b1;
          byte_cnt_d     = byte_cnt_q + 2'd1;
          if (last_byte) state_d = DONE;
        end
      end
      RDATA: begin
        // bit_cnt counts master sample edges; zero on a fall means a whole byte went out.
        if (sclk_rise && rd_loaded_q) begin
          bit_cnt_d = (bit_cnt_q == 4'd7) ? 4'd0 : bit_cnt_q + 4'd1;
        end else if (sclk_fall) begin
          if (!rd_loaded_q) begin
            rd_loaded_d = 1'b1;
            oe_d        = 1'b1;
            shift_d     = regs_q[addr_q];
            sdio_o_d    = regs_q[addr_q][7];
          end else if (bit_cnt_q == 4'd0) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (last_byte) begin
              oe_d    = 1'b0;
              state_d = DONE;
            end else begin
              addr_d   = addr_q - 1'b1;
              shift_d  = rd_byte;
              sdio_o_d = rd_byte[7];
            end
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sdio_o_d = shift_q[6];
          end
        end
      end
      default: ;
    endcase

    if (cs_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      sclk_sync_q  <= '0;
      cs_sync_q    <= '0;
      sdio_sync_q  <= '0;
      sclk_d1_q    <= 1'b0;
      cs_d1_q      <= 1'b0;
      instr_q      <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      mode_q       <= '0;
      addr_q       <= '0;
      shift_q      <= '0;
      rd_loaded_q  <= 1'b0;
      oe_q         <= 1'b0;
      sdio_o_q     <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      host_rdata_q <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      sdio_sync_q  <= sdio_sync_d;
      sclk_d1_q    <= sclk_d1_d;
      cs_d1_q      <= cs_d1_d;
      instr_q      <= instr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      shift_q      <= shift_d;
      rd_loaded_q  <= rd_loaded_d;
      oe_q         <= oe_d;
      sdio_o_q     <= sdio_o_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      host_rdata_q <= host_rdata_d;
      regs_q       <= regs_d;
    end
  end

`ifdef SPI_SLV_ERR_CNT_EN
  logic abort;
  logic [7:0] err_cnt_q, err_cnt_d;
  // A deselect on a byte boundary or after the counted bytes is a clean end, not an abort.
  assign abort = cs_rise && ((state_q == INSTR) ||
                 (((state_q == WDATA) || (state_q == RDATA)) && (bit_cnt_q != 4'd0)));
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (abort && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (!rstn) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end
  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.spi_sdio_o  = sdio_o_q;
  assign bus.spi_sdio_oe = oe_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.wr_valid    = wr_valid_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.host_rdata  = host_rdata_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_spi3w_slave_regfile.sv
// Directed plus randomized transactions against a byte-array model of the SPI register file.
module tb_spi3w_slave_regfile;
  localparam int REG_DEPTH = 64;
  localparam int ADDR_W    = 6;
  localparam int HALF      = 32;

  logic clk = 1'b0;
  logic rstn;
  logic mst_sdio;
  logic [2:0] dbg_state;
  int total = 0;
  int bad = 0;
  int aborts = 0;

  logic [7:0] ref_regs [REG_DEPTH];
  logic [7:0] tx_bytes [8];
  logic [7:0] rx_bytes [8];
  logic [7:0] exp_rx [8];
  logic [13:0] exp_q[$];
  logic [13:0] wr_log[$];
  logic [7:0]  hr_log[$];
  logic oe_instr_any, oe_data_all1;

  spi3w_slave_regfile_if #(.ADDR_W(ADDR_W)) sif ();
  assign sif.spi_sdio_i = sif.spi_sdio_oe ? sif.spi_sdio_o : mst_sdio;

  spi3w_slave_regfile #(.REG_DEPTH(REG_DEPTH), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .bus(sif), .dbg_state(dbg_state)
  );

  always #25 clk = ~clk;

  always @(negedge clk) begin
    if (sif.wr_valid === 1'b1) begin
      wr_log.push_back({sif.wr_addr, sif.wr_data});
      hr_log.push_back(sif.host_rdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_err();
`ifdef SPI_SLV_ERR_CNT_EN
    return (aborts > 255) ? 8'hFF : 8'(aborts);
`else
    return 8'h00;
`endif
  endfunction

  task automatic cs_low();
    @(negedge clk);
    sif.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    sif.spi_cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic out_bit, output logic in_bit, output logic oe_s);
    mst_sdio = out_bit;
    repeat (HALF) @(negedge clk);
    in_bit = sif.spi_sdio_i;
    oe_s   = sif.spi_sdio_oe;
    sif.spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sif.spi_sclk = 1'b0;
  endtask

  task automatic spi_txn(input logic [15:0] instr, input int nbytes, input int extra_bits);
    logic b, oe_s;
    oe_instr_any = 1'b0;
    oe_data_all1 = 1'b1;
    cs_low();
    for (int i = 15; i >= 0; i--) begin
      xfer_bit(instr[i], b, oe_s);
      oe_instr_any |= oe_s;
    end
    mst_sdio = 1'b0;
    for (int k = 0; k < nbytes; k++) begin
      for (int j = 7; j >= 0; j--) begin
        xfer_bit(instr[15] ? 1'b0 : tx_bytes[k][j], b, oe_s);
        rx_bytes[k][j] = b;
        oe_data_all1 &= oe_s;
      end
    end
    for (int e = 0; e < extra_bits; e++) xfer_bit(tx_bytes[nbytes][7-e], b, oe_s);
    mst_sdio = 1'b0;
    cs_high();
  endtask

  // Reference: counted bytes at addr, addr-1, ... modulo depth; deselect mid-byte is an abort.
  task automatic do_txn(input string tag, input logic [15:0] instr, input int nbytes, input int extra_bits);
    int cnt, n_eff, a0, a;
    cnt   = int'(instr[14:13]);
    n_eff = (cnt == 3) ? nbytes : ((nbytes < cnt + 1) ? nbytes : cnt + 1);
    a0    = int'(instr[12:0]) % REG_DEPTH;
    exp_q.delete();
    wr_log.delete();
    hr_log.delete();
    for (int i = 0; i < n_eff; i++) begin
      a = (a0 - i + 4 * REG_DEPTH) % REG_DEPTH;
      if (instr[15]) exp_rx[i] = ref_regs[a];
      else exp_q.push_back({ADDR_W'(a), tx_bytes[i]});
    end
    if (extra_bits > 0 && (cnt == 3 || nbytes < cnt + 1)) aborts++;
    spi_txn(instr, nbytes, extra_bits);
    foreach (exp_q[i]) ref_regs[exp_q[i][7+ADDR_W:8]] = exp_q[i][7:0];
    check({tag, " wr_count"}, wr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
      check($sformatf("%s wr%0d", tag, i), wr_log[i], exp_q[i]);
    check({tag, " oe_in_instr"}, oe_instr_any, 1'b0);
    if (instr[15]) begin
      for (int i = 0; i < n_eff; i++) check($sformatf("%s rd%0d", tag, i), rx_bytes[i], exp_rx[i]);
      check({tag, " oe_data"}, oe_data_all1, 1'b1);
    end
    check({tag, " oe_end"}, sif.spi_sdio_oe, 1'b0);
    check({tag, " busy_end"}, sif.busy, 1'b0);
    check({tag, " err_cnt"}, sif.err_cnt, exp_err());
  endtask

  task automatic host_check(input string tag, input int addr);
    @(negedge clk);
    sif.host_addr = ADDR_W'(addr);
    repeat (2) @(negedge clk);
    check(tag, sif.host_rdata, ref_regs[addr]);
  endtask

  initial begin
    logic b, oe_s;
    logic [15:0] instr;
    int nb;
    rstn = 1'b0;
    sif.spi_cs_n = 1'b1;
    sif.spi_sclk = 1'b0;
    sif.host_addr = '0;
    mst_sdio = 1'b0;
    for (int i = 0; i < REG_DEPTH; i++) ref_regs[i] = 8'h00;
    repeat (4) @(negedge clk);
    check("rst busy", sif.busy, 1'b0);
    check("rst oe", sif.spi_sdio_oe, 1'b0);
    check("rst sdio_o", sif.spi_sdio_o, 1'b0);
    check("rst wr_valid", sif.wr_valid, 1'b0);
    check("rst host_rdata", sif.host_rdata, 8'h00);
    check("rst err_cnt", sif.err_cnt, 8'h00);
    rstn = 1'b1;
    repeat (8) @(negedge clk);

    tx_bytes[0] = 8'hA5;
    do_txn("t1", 16'h0010, 1, 0);
    host_check("t1 host", 16);
    do_txn("t2", 16'h8010, 1, 0);

    // Host reads the address being committed: the old value must come back.
    @(negedge clk);
    sif.host_addr = 6'h10;
    tx_bytes[0] = 8'h3C;
    do_txn("coll", 16'h0010, 1, 0);
    if (hr_log.size() > 0) check("coll old", hr_log[0], 8'hA5);
    host_check("coll new", 16);

    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
    do_txn("t3", 16'h4012, 3, 0);
    host_check("t3 h12", 18);
    host_check("t3 h10", 16);

    tx_bytes[0] = 8'h5A; tx_bytes[1] = 8'hC3;
    do_txn("t4", 16'h2000, 2, 0);
    host_check("t4 h3f", 63);
    tx_bytes[0] = 8'h77;
    do_txn("t4b", 16'h1FC1, 1, 0);
    host_check("t4b h01", 1);
    do_txn("t4r", 16'hA001, 2, 0);

    tx_bytes[0] = 8'hFF;
    do_txn("t5 abort", 16'h0005, 0, 4);
    tx_bytes[0] = 8'h66;
    do_txn("t5 next", 16'h0005, 1, 0);
    host_check("t5 h05", 5);

    // Reset pulse in the middle of a read byte.
    cs_low();
    instr = 16'h8010;
    for (int i = 15; i >= 0; i--) xfer_bit(instr[i], b, oe_s);
    for (int i = 0; i < 3; i++) xfer_bit(1'b0, b, oe_s);
    check("t6 oe_before", sif.spi_sdio_oe, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("t6 oe", sif.spi_sdio_oe, 1'b0);
    check("t6 busy", sif.busy, 1'b0);
    for (int i = 0; i < REG_DEPTH; i++) ref_regs[i] = 8'h00;
    aborts = 0;
    cs_high();
    check("t6 err_cnt", sif.err_cnt, exp_err());
    host_check("t6 h10", 16);
    do_txn("t6 rd", 16'h8010, 1, 0);

    for (int r = 0; r < 8; r++) begin
      instr = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 13'($urandom_range(0, 8191))};
      nb = (instr[14:13] == 2'b11) ? int'($urandom_range(1, 3)) : int'(instr[14:13]) + 1;
      for (int i = 0; i < 8; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
      do_txn($sformatf("rnd%0d", r), instr, nb, 0);
    end

    for (int a = 0; a < REG_DEPTH; a++) host_check($sformatf("sweep%0d", a), a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
